// File: rtl/unary_add_driver_1_4_13_if.sv
// Purpose: host-side and adder-side signal bundle for the unary adder driver.
// Latency: none; this is wiring only.
// Backpressure: none; start is a level request sampled by the driver when it is idle.
// Ports: start/op_a/op_b (host request), busy/done/sum/err (host result),
//        A/B/en/read_or_write (to adder), dout/C (from adder).
interface unary_add_driver_1_4_13_if #(
    parameter int MOD = 14,
    parameter int W   = 4
);
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W:0]   sum;
    logic         err;
    logic         A;
    logic         B;
    logic         en;
    logic         read_or_write;
    logic         dout;
    logic         C;

    // The environment side: host requests plus the adder's registered outputs.
    modport master (
        output start, op_a, op_b, dout, C,
        input  busy, done, sum, err, A, B, en, read_or_write
    );

    // The driver side.
    modport slave (
        input  start, op_a, op_b, dout, C,
        output busy, done, sum, err, A, B, en, read_or_write
    );
endinterface

// File: rtl/unary_add_driver_1_4_13.sv
// Purpose: converts two binary operands to unary pulse trains for a mod-MOD unary adder and counts the result back.
// Latency: max(a,b) + 1 + ((a+b) mod MOD + 2) + 1 cycles from the start edge to the done strobe.
// Backpressure: none; start is honoured only in IDLE, and requests while busy are dropped without queuing.
// Ports: clk, rst_n (async active-low); bus.slave carries start/op_a/op_b in,
//        busy/done/sum/err out, A/B/en/read_or_write to the adder, dout/C from the adder.
module unary_add_driver_1_4_13 #(
    parameter int MOD = 14,
    parameter int W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    unary_add_driver_1_4_13_if.slave     bus
);

    // n must be able to hold MOD itself so an overrun is detectable.
    localparam int            NW      = $clog2(MOD + 1);
    localparam logic [W-1:0]  OP_MAX  = W'(MOD - 1);
    localparam logic [NW-1:0] N_MAX   = NW'(MOD);
    localparam logic [W:0]    MOD_SUM = (W + 1)'(MOD);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        TURN = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_q;
    logic [W-1:0]  ra_q, rb_q;
    logic [W-1:0]  ra_d, rb_d;
    logic [NW-1:0] n_q;
    logic          carry_q;
    logic          err_pend_q;
    logic          first_q;

    logic          busy_q, done_q, err_q;
    logic          a_q, b_q, en_q, rw_q;
    logic [W:0]    sum_q;

    logic          clamp_a, clamp_b;
    logic [W-1:0]  ra_clamp, rb_clamp;
    logic [W:0]    sum_d;

    always_comb begin
        clamp_a  = (bus.op_a > OP_MAX);
        clamp_b  = (bus.op_b > OP_MAX);
        ra_clamp = clamp_a ? OP_MAX : bus.op_a;
        rb_clamp = clamp_b ? OP_MAX : bus.op_b;
        // Remainders saturate at zero so the shorter operand simply stops pulsing.
        ra_d     = (ra_q != '0) ? (ra_q - W'(1)) : ra_q;
        rb_d     = (rb_q != '0) ? (rb_q - W'(1)) : rb_q;
        sum_d    = carry_q ? (MOD_SUM + (W + 1)'(n_q)) : (W + 1)'(n_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ra_q       <= '0;
            rb_q       <= '0;
            n_q        <= '0;
            carry_q    <= 1'b0;
            err_pend_q <= 1'b0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sum_q      <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            en_q       <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        ra_q       <= ra_clamp;
                        rb_q       <= rb_clamp;
                        err_pend_q <= clamp_a | clamp_b;
                        carry_q    <= 1'b0;
                        n_q        <= '0;
                        busy_q     <= 1'b1;
                        en_q       <= 1'b1;
                        rw_q       <= 1'b0;
                        if ((ra_clamp | rb_clamp) != '0) begin
                            state_q <= SEND;
                            a_q     <= (ra_clamp != '0);
                            b_q     <= (rb_clamp != '0);
                        end else begin
                            state_q <= TURN;
                        end
                    end
                end

                SEND: begin
                    // The adder's C is registered, so it reflects the previous pulse.
                    carry_q <= carry_q | bus.C;
                    ra_q    <= ra_d;
                    rb_q    <= rb_d;
                    a_q     <= (ra_d != '0);
                    b_q     <= (rb_d != '0);
                    if ((ra_d == '0) && (rb_d == '0)) begin
                        state_q <= TURN;
                    end
                end

                TURN: begin
                    // Idle read cycle so a carry from the final SEND pulse is seen.
                    carry_q <= carry_q | bus.C;
                    rw_q    <= 1'b1;
                    first_q <= 1'b1;
                    state_q <= RECV;
                end

                RECV: begin
                    if (first_q) begin
                        // dout is still the adder's read-phase value here.
                        first_q <= 1'b0;
                    end else if (bus.dout && (n_q == N_MAX)) begin
                        err_pend_q <= 1'b1;
                        state_q    <= DONE;
                        en_q       <= 1'b0;
                        rw_q       <= 1'b0;
                        done_q     <= 1'b1;
                        sum_q      <= sum_d;
                        err_q      <= 1'b1;
                    end else if (bus.dout) begin
                        n_q <= n_q + NW'(1);
                    end else begin
                        state_q <= DONE;
                        en_q    <= 1'b0;
                        rw_q    <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= sum_d;
                        err_q   <= err_pend_q;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                    en_q    <= 1'b0;
                    rw_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sum           = sum_q;
    assign bus.err           = err_q;
    assign bus.A             = a_q;
    assign bus.B             = b_q;
    assign bus.en            = en_q;
    assign bus.read_or_write = rw_q;

endmodule

// File: tb/tb_unary_add_driver_1_4_13.sv
module tb_unary_add_driver_1_4_13;
    localparam int MOD = 14;
    localparam int W   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unary_add_driver_1_4_13_if #(.MOD(MOD), .W(W)) bus ();

    unary_add_driver_1_4_13 #(.MOD(MOD), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural mod-MOD unary adder: counts A/B pulses in read phase with a
    // registered carry, drains the count one pulse per cycle on dout in write phase.
    int unsigned acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= 0;
            bus.C    <= 1'b0;
            bus.dout <= 1'b0;
        end else if (bus.en && !bus.read_or_write) begin
            bus.dout <= 1'b0;
            if (acc + bus.A + bus.B >= MOD) begin
                acc   <= acc + bus.A + bus.B - MOD;
                bus.C <= 1'b1;
            end else begin
                acc   <= acc + bus.A + bus.B;
                bus.C <= 1'b0;
            end
        end else if (bus.en && bus.read_or_write) begin
            bus.C <= 1'b0;
            if (acc != 0) begin
                bus.dout <= 1'b1;
                acc      <= acc - 1;
            end else begin
                bus.dout <= 1'b0;
            end
        end else begin
            bus.C    <= 1'b0;
            bus.dout <= 1'b0;
        end
    end

    // Free-running activity counters; tests work with deltas.
    int a_hi = 0, b_hi = 0, ab_hi = 0, recv_cyc = 0, done_cnt = 0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.en && !bus.read_or_write && bus.A) a_hi++;
            if (bus.en && !bus.read_or_write && bus.B) b_hi++;
            if (bus.en && !bus.read_or_write && bus.A && bus.B) ab_hi++;
            if (bus.en && bus.read_or_write) recv_cyc++;
            if (bus.done) done_cnt++;
        end
    end

    typedef struct {
        logic [W:0] sum;
        logic       err;
        int         lat;
        int         recv;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int snap_a, snap_b, snap_ab, snap_recv, snap_done;

    // Pushes the expected result, then presents one start pulse; returns #1 after the sampling edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ca, cb;
        ca     = (int'(a) > MOD - 1) ? MOD - 1 : int'(a);
        cb     = (int'(b) > MOD - 1) ? MOD - 1 : int'(b);
        e.sum  = (W + 1)'(ca + cb);
        e.err  = (int'(a) > MOD - 1) || (int'(b) > MOD - 1);
        e.recv = (ca + cb) % MOD + 2;
        e.lat  = ((ca > cb) ? ca : cb) + 1 + e.recv + 1;
        sb.push_back(e);
        snap_a    = a_hi;
        snap_b    = b_hi;
        snap_ab   = ab_hi;
        snap_recv = recv_cyc;
        snap_done = done_cnt;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output bit to);
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        to = (bus.done !== 1'b1);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.sum, bus.err, bus.A, bus.B, bus.en, bus.read_or_write} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%0d err=%b A=%b B=%b en=%b rw=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.err, bus.A, bus.B, bus.en, bus.read_or_write);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_basic;
        exp_t e; int lat; bit to;
        issue(4'd5, 4'd3);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", bus.busy); end
        wait_done(1, lat, to);
        e = sb.pop_front();
        total++;
        if (to) begin bad++; $display("FAIL done_timeout_5_3: no done within %0d cycles", lat); end
        total++;
        if (bus.sum !== e.sum || bus.err !== e.err) begin
            bad++; $display("FAIL sum_5_3: got sum=%0d err=%b want sum=%0d err=%b", bus.sum, bus.err, e.sum, e.err);
        end
        total++;
        if (lat !== e.lat) begin bad++; $display("FAIL latency_5_3: got %0d want %0d", lat, e.lat); end
        total++;
        if (a_hi - snap_a !== 5 || b_hi - snap_b !== 3 || ab_hi - snap_ab !== 3) begin
            bad++; $display("FAIL pulses_5_3: got A=%0d B=%0d both=%0d want 5 3 3", a_hi - snap_a, b_hi - snap_b, ab_hi - snap_ab);
        end
        total++;
        if (recv_cyc - snap_recv !== e.recv) begin
            bad++; $display("FAIL recv_5_3: got %0d want %0d", recv_cyc - snap_recv, e.recv);
        end
        @(posedge clk);
        #1;
        total++;
        if ({bus.done, bus.busy} !== 2'b00 || bus.sum !== e.sum) begin
            bad++; $display("FAIL done_one_cycle: got done=%b busy=%b sum=%0d want 0 0 %0d", bus.done, bus.busy, bus.sum, e.sum);
        end
    endtask

    task automatic test_carry_13_13;
        exp_t e; int lat; bit to;
        issue(4'd13, 4'd13);
        wait_done(1, lat, to);
        e = sb.pop_front();
        total++;
        if (to || bus.sum !== e.sum || bus.err !== e.err) begin
            bad++; $display("FAIL sum_13_13: got sum=%0d err=%b timeout=%b want sum=%0d err=%b", bus.sum, bus.err, to, e.sum, e.err);
        end
        total++;
        if (lat !== e.lat) begin bad++; $display("FAIL latency_13_13: got %0d want %0d", lat, e.lat); end
        total++;
        if (acc !== 0) begin bad++; $display("FAIL adder_drained_13_13: got %0d want 0", acc); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry_7_7;
        exp_t e; int lat; bit to;
        issue(4'd7, 4'd7);
        wait_done(1, lat, to);
        e = sb.pop_front();
        total++;
        if (to || bus.sum !== e.sum || bus.err !== e.err) begin
            bad++; $display("FAIL sum_7_7: got sum=%0d err=%b timeout=%b want sum=%0d err=%b", bus.sum, bus.err, to, e.sum, e.err);
        end
        total++;
        if (recv_cyc - snap_recv !== e.recv || lat !== e.lat) begin
            bad++; $display("FAIL timing_7_7: got recv=%0d lat=%0d want recv=%0d lat=%0d", recv_cyc - snap_recv, lat, e.recv, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero;
        exp_t e; int lat; bit to;
        issue(4'd0, 4'd0);
        wait_done(1, lat, to);
        e = sb.pop_front();
        total++;
        if (to || bus.sum !== e.sum || bus.err !== e.err) begin
            bad++; $display("FAIL sum_0_0: got sum=%0d err=%b timeout=%b want sum=%0d err=%b", bus.sum, bus.err, to, e.sum, e.err);
        end
        total++;
        if (lat !== e.lat || a_hi - snap_a !== 0 || b_hi - snap_b !== 0) begin
            bad++; $display("FAIL timing_0_0: got lat=%0d A=%0d B=%0d want lat=%0d A=0 B=0", lat, a_hi - snap_a, b_hi - snap_b, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clamp_and_ignored_start;
        exp_t e; int lat; bit to;
        issue(4'd15, 4'd2);
        repeat (2) begin @(posedge clk); #1; end
        // A second request while busy must be dropped.
        bus.op_a  = 4'd1;
        bus.op_b  = 4'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(4, lat, to);
        e = sb.pop_front();
        total++;
        if (to || bus.sum !== e.sum || bus.err !== e.err) begin
            bad++; $display("FAIL clamp_15_2: got sum=%0d err=%b timeout=%b want sum=%0d err=%b", bus.sum, bus.err, to, e.sum, e.err);
        end
        total++;
        if (lat !== e.lat) begin bad++; $display("FAIL latency_15_2: got %0d want %0d", lat, e.lat); end
        repeat (30) begin @(posedge clk); #1; end
        total++;
        if (done_cnt - snap_done !== 1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL ignored_start: got dones=%0d busy=%b want 1 0", done_cnt - snap_done, bus.busy);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e; int lat; bit to;
        issue(4'd2, 4'd6);
        wait_done(1, lat, to);
        e = sb.pop_front();
        total++;
        if (to || bus.sum !== e.sum || bus.err !== e.err) begin
            bad++; $display("FAIL sum_2_6: got sum=%0d err=%b timeout=%b want sum=%0d err=%b", bus.sum, bus.err, to, e.sum, e.err);
        end
        @(posedge clk);
        #1;
        issue(4'd10, 4'd11);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_start_taken: busy=%b want 1", bus.busy); end
        wait_done(1, lat, to);
        e = sb.pop_front();
        total++;
        if (to || bus.sum !== e.sum || bus.err !== e.err || lat !== e.lat) begin
            bad++; $display("FAIL sum_10_11: got sum=%0d err=%b lat=%0d want sum=%0d err=%b lat=%0d", bus.sum, bus.err, lat, e.sum, e.err, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        exp_t e; int lat; bit to; int k;
        issue(4'd9, 4'd4);
        k = 0;
        while (bus.read_or_write !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
        total++;
        if (bus.read_or_write !== 1'b1) begin bad++; $display("FAIL reach_recv: rw=%b want 1", bus.read_or_write); end
        repeat (2) begin @(posedge clk); #1; end
        #3;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        total++;
        if ({bus.busy, bus.done, bus.sum, bus.err, bus.A, bus.B, bus.en, bus.read_or_write} !== 12'd0) begin
            bad++; $display("FAIL async_reset_mid: got busy=%b done=%b sum=%0d err=%b en=%b rw=%b want all 0",
                            bus.busy, bus.done, bus.sum, bus.err, bus.en, bus.read_or_write);
        end
        snap_done = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        total++;
        if (done_cnt - snap_done !== 0) begin bad++; $display("FAIL no_done_after_reset: got %0d want 0", done_cnt - snap_done); end
        issue(4'd1, 4'd1);
        wait_done(1, lat, to);
        e = sb.pop_front();
        total++;
        if (to || bus.sum !== e.sum || bus.err !== e.err || lat !== e.lat) begin
            bad++; $display("FAIL sum_1_1: got sum=%0d err=%b lat=%0d want sum=%0d err=%b lat=%0d", bus.sum, bus.err, lat, e.sum, e.err, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        test_reset;
        test_basic;
        test_carry_13_13;
        test_carry_7_7;
        test_zero;
        test_clamp_and_ignored_start;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
